// File: rtl/line_buffer_param.sv
// Single-line circular pixel buffer presenting a KERNEL-wide horizontal window per read.
// Window taps wrap or clamp at the line end depending on BORDER.
module line_buffer_param #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 512,
  parameter int KERNEL = 3,
  parameter int BORDER = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_data_valid,
  input  logic                         i_rd_data,
  output logic [KERNEL*DATA_W-1:0]     o_data,
  output logic                         o_data_valid,
  output logic [$clog2(LINE_W+1)-1:0]  o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_rd_line_done,
  output logic                         o_ovf,
  output logic                         o_udf
);

  localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int CNT_W = $clog2(LINE_W + 1);
  localparam int SUM_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(LINE_W);
  localparam logic [SUM_W-1:0] LINE_S = SUM_W'(LINE_W);
  localparam logic [SUM_W-1:0] LAST_S = SUM_W'(LINE_W - 1);

  logic [DATA_W-1:0]        mem_q [LINE_W];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [KERNEL*DATA_W-1:0] data_q, data_d;
  logic [KERNEL*DATA_W-1:0] window_s;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     full_s, empty_s, rd_acc_s, wr_acc_s;

  // The sum is one bit wider than a pointer so rd_ptr+k never overflows before wrap/clamp.
  function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] base, input int k);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(k);
    if (BORDER == 0) begin
      if (sum >= LINE_S) begin
        sum = sum - LINE_S;
      end else begin
        sum = sum;
      end
    end else begin
      if (sum > LAST_S) begin
        sum = LAST_S;
      end else begin
        sum = sum;
      end
    end
    return sum[PTR_W-1:0];
  endfunction

  assign full_s   = (count_q == FULL_C);
  assign empty_s  = (count_q == '0);
  assign rd_acc_s = i_rd_data && !empty_s;
  assign wr_acc_s = i_data_valid && (!full_s || rd_acc_s);

  for (genvar k = 0; k < KERNEL; k++) begin : g_tap
    assign window_s[(KERNEL-1-k)*DATA_W +: DATA_W] = mem_q[tap_addr(rd_ptr_q, k)];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (rd_acc_s) begin
      data_d   = window_s;
      valid_d  = 1'b1;
      done_d   = (rd_ptr_q == LAST_P);
      rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PTR_W'(1);
    end else if (i_rd_data) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_q;
    end

    if (wr_acc_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PTR_W'(1);
    end else if (i_data_valid) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (wr_acc_s && !rd_acc_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Line RAM is not reset; taps read the pre-edge contents (no write forwarding).
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data         = data_q;
  assign o_data_valid   = valid_q;
  assign o_count        = count_q;
  assign o_full         = full_s;
  assign o_empty        = empty_s;
  assign o_rd_line_done = done_q;
  assign o_ovf          = ovf_q;
  assign o_udf          = udf_q;

endmodule

// File: tb/tb_line_buffer_param.sv
// Scoreboard bench: three buffers (8/wrap, 8/replicate, 5/wrap) share one random+directed stimulus.
module tb_line_buffer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] din = 8'h00;

  logic [23:0] dd [3];
  logic        vo [3];
  logic        ldo [3];
  logic        fo [3];
  logic        eo [3];
  logic        ovo [3];
  logic        udo [3];
  logic [3:0]  c0, c1;
  logic [2:0]  c2;

  line_buffer_param #(.DATA_W(8), .LINE_W(8), .KERNEL(3), .BORDER(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_data_valid(dv), .i_rd_data(rd),
    .o_data(dd[0]), .o_data_valid(vo[0]), .o_count(c0), .o_full(fo[0]), .o_empty(eo[0]),
    .o_rd_line_done(ldo[0]), .o_ovf(ovo[0]), .o_udf(udo[0]));

  line_buffer_param #(.DATA_W(8), .LINE_W(8), .KERNEL(3), .BORDER(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_data_valid(dv), .i_rd_data(rd),
    .o_data(dd[1]), .o_data_valid(vo[1]), .o_count(c1), .o_full(fo[1]), .o_empty(eo[1]),
    .o_rd_line_done(ldo[1]), .o_ovf(ovo[1]), .o_udf(udo[1]));

  line_buffer_param #(.DATA_W(8), .LINE_W(5), .KERNEL(3), .BORDER(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_data_valid(dv), .i_rd_data(rd),
    .o_data(dd[2]), .o_data_valid(vo[2]), .o_count(c2), .o_full(fo[2]), .o_empty(eo[2]),
    .o_rd_line_done(ldo[2]), .o_ovf(ovo[2]), .o_udf(udo[2]));

  // Reference model: line as an array, occupancy as an integer, addresses via % and min.
  int lw [3] = '{8, 8, 5};
  int bd [3] = '{0, 1, 0};
  logic [7:0]  mm [3][8];
  bit          kn [3][8];
  int          wp [3], rp [3], cn [3];
  bit          ov [3], ud [3];
  logic [23:0] ed [3], em [3];

  typedef struct {
    int          inst;
    logic [23:0] d;
    logic [23:0] m;
    bit          ld;
  } exp_t;
  exp_t sbq [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit   ra, wa;
    int   a;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        wp[i] = 0; rp[i] = 0; cn[i] = 0; ov[i] = 1'b0; ud[i] = 1'b0;
        ed[i] = 24'h0; em[i] = 24'hFFFFFF;
      end else begin
        ra = rd && (cn[i] > 0);
        wa = dv && ((cn[i] < lw[i]) || ra);
        if (ra) begin
          e.inst = i; e.d = 24'h0; e.m = 24'h0;
          for (int k = 0; k < 3; k++) begin
            a = rp[i] + k;
            if (bd[i] == 0) a = a % lw[i];
            else if (a > lw[i] - 1) a = lw[i] - 1;
            e.d[23-8*k -: 8] = mm[i][a];
            e.m[23-8*k -: 8] = kn[i][a] ? 8'hFF : 8'h00;
          end
          e.ld = (rp[i] == lw[i] - 1);
          sbq.push_back(e);
          ed[i] = e.d; em[i] = e.m;
          rp[i] = (rp[i] + 1) % lw[i];
        end
        if (rd && !ra) ud[i] = 1'b1;
        if (dv && !wa) ov[i] = 1'b1;
        if (wa) begin
          mm[i][wp[i]] = din; kn[i][wp[i]] = 1'b1;
          wp[i] = (wp[i] + 1) % lw[i];
        end
        cn[i] = cn[i] + int'(wa) - int'(ra);
      end
    end
  end

  // Monitor: pops one expected window per presented o_data_valid and checks status every cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] cv;
    for (int i = 0; i < 3; i++) begin
      if (vo[i]) begin
        if (sbq.size() > 0 && sbq[0].inst == i) begin
          e = sbq.pop_front();
          chk("window", i, dd[i] & e.m, e.d & e.m);
          chk("line_done", i, ldo[i], e.ld);
        end else begin
          chk("spurious_valid", i, vo[i], 1'b0);
        end
      end else begin
        chk("line_done_idle", i, ldo[i], 1'b0);
      end
      chk("data_hold", i, dd[i] & em[i], ed[i] & em[i]);
      cv = (i == 0) ? 32'(c0) : (i == 1) ? 32'(c1) : 32'(c2);
      chk("count", i, cv, cn[i]);
      chk("full", i, fo[i], cn[i] == lw[i]);
      chk("empty", i, eo[i], cn[i] == 0);
      chk("ovf", i, ovo[i], ov[i]);
      chk("udf", i, udo[i], ud[i]);
    end
    if (sbq.size() > 0) begin
      chk("missing_valid", sbq[0].inst, vo[sbq[0].inst], 1'b1);
      sbq.delete();
    end
  end

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit q);
    rst = r; dv = w; din = d; rd = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random requests
    for (int j = 0; j < 2; j++) step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", i, dd[i], 24'h0);
      chk("rst_valid", i, vo[i], 1'b0);
      chk("rst_empty", i, eo[i], 1'b1);
      chk("rst_ovf", i, ovo[i], 1'b0);
    end
    chk("rst_count", 0, c0, 4'd0);

    // Fill and read across the line end
    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 8'h10 + 8'(j), 1'b0);
    chk("fill_full", 0, fo[0], 1'b1);
    chk("fill_count", 0, c0, 4'd8);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("first_win", 0, dd[0], 24'h101112);
    chk("first_valid", 0, vo[0], 1'b1);
    chk("first_count", 0, c0, 4'd7);
    chk("first_win", 1, dd[1], 24'h101112);
    for (int j = 1; j < 6; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("col6_wrap", 0, dd[0], 24'h161710);
    chk("col6_clamp", 1, dd[1], 24'h161717);
    chk("col6_done", 1, ldo[1], 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("col7_wrap", 0, dd[0], 24'h171011);
    chk("col7_done", 0, ldo[0], 1'b1);
    chk("col7_clamp", 1, dd[1], 24'h171717);
    chk("col7_done", 1, ldo[1], 1'b1);

    // Empty boundary
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("empty_rd_valid", 0, vo[0], 1'b0);
    chk("empty_rd_udf", 0, udo[0], 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("empty_wr_rd_count", 0, c0, 4'd1);
    chk("empty_wr_rd_valid", 0, vo[0], 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_udf", 0, udo[0], 1'b0);
    chk("rst_ovf", 2, ovo[2], 1'b0);

    // Full boundary
    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 8'h10 + 8'(j), 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("full_drop_ovf", 0, ovo[0], 1'b1);
    chk("full_drop_count", 0, c0, 4'd8);
    step(1'b0, 1'b1, 8'hBB, 1'b1);
    chk("full_wr_rd_count", 0, c0, 4'd8);
    chk("full_wr_rd_win", 0, dd[0], 24'h101112);
    chk("full_wr_rd_ovf", 0, ovo[0], 1'b1);
    for (int j = 1; j < 7; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bb_in_col0", 0, dd[0], 24'h1617BB);

    // Non-power-of-two line
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int j = 1; j <= 5; j++) step(1'b0, 1'b1, 8'(j), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("np2_col0", 2, dd[2], 24'h010203);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("np2_col1", 2, dd[2], 24'h020304);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("np2_col2", 2, dd[2], 24'h030405);
    step(1'b0, 1'b1, 8'h06, 1'b0);
    chk("np2_count", 2, c2, 3'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("np2_col3", 2, dd[2], 24'h040506);

    // Randomized traffic with occasional reset
    for (int j = 0; j < 800; j++) begin
      step($urandom_range(0, 59) == 0, 1'($urandom), 8'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
